// File: rtl/ball_motion.sv
// ball_motion: ball position/direction controller for the Pong datapath.
// Moves the ball once per tick, reflects it off collision flags and the
// top/bottom walls, and runs an IDLE -> SERVE -> PLAY -> MISS rally FSM.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   tick                       one-cycle update strobe
//   coll_x1/x2, coll_y1/y2     collision flags (*1 forces +, *2 forces -)
//   speed_x, speed_y           per-axis step per tick
//   serve_req, serve_dir       serve request and initial X direction
//   ball_x, ball_y             registered ball position
//   dir_x, dir_y               registered direction (1 = decreasing)
//   in_play                    high while in PLAY
//   miss_left, miss_right      one-cycle miss pulses
module ball_motion #(
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int SPD_W       = 3,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int SERVE_X     = 320,
    parameter int SERVE_Y     = 240,
    parameter int SERVE_DELAY = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             coll_x1,
    input  logic             coll_x2,
    input  logic             coll_y1,
    input  logic             coll_y2,
    input  logic [SPD_W-1:0] speed_x,
    input  logic [SPD_W-1:0] speed_y,
    input  logic             serve_req,
    input  logic             serve_dir,
    output logic [X_W-1:0]   ball_x,
    output logic [Y_W-1:0]   ball_y,
    output logic             dir_x,
    output logic             dir_y,
    output logic             in_play,
    output logic             miss_left,
    output logic             miss_right
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SERVE = 2'd1;
    localparam logic [1:0] PLAY  = 2'd2;
    localparam logic [1:0] MISS  = 2'd3;

    localparam logic [X_W:0]   xMinE      = X_MIN[X_W:0];
    localparam logic [X_W:0]   xMaxE      = X_MAX[X_W:0];
    localparam logic [Y_W:0]   yMinE      = Y_MIN[Y_W:0];
    localparam logic [Y_W:0]   yMaxE      = Y_MAX[Y_W:0];
    localparam logic [X_W-1:0] serveX     = SERVE_X[X_W-1:0];
    localparam logic [Y_W-1:0] serveY     = SERVE_Y[Y_W-1:0];
    localparam logic [7:0]     serveDelay = SERVE_DELAY[7:0];

    logic [1:0]     state, stateNext;
    logic [X_W-1:0] posX, posXNext;
    logic [Y_W-1:0] posY, posYNext;
    logic           dirX, dirXNext;
    logic           dirY, dirYNext;
    logic [7:0]     cnt, cntNext;
    logic           missRight, missRightNext;

    // One extra bit on every comparison so sums and differences never wrap.
    logic [X_W:0] spdX, posXE, xSum, xDiff, xLow;
    logic [Y_W:0] spdY, posYE, ySum, yDiff, yLow;

    assign spdX  = {{(X_W + 1 - SPD_W){1'b0}}, speed_x};
    assign spdY  = {{(Y_W + 1 - SPD_W){1'b0}}, speed_y};
    assign posXE = {1'b0, posX};
    assign posYE = {1'b0, posY};
    assign xSum  = posXE + spdX;
    assign xDiff = posXE - spdX;
    assign xLow  = xMinE + spdX;
    assign ySum  = posYE + spdY;
    assign yDiff = posYE - spdY;
    assign yLow  = yMinE + spdY;

    always_comb begin
        logic ndx;
        logic ndy;
        logic missHit;
        ndx           = dirX;
        ndy           = dirY;
        missHit       = 1'b0;
        stateNext     = state;
        posXNext      = posX;
        posYNext      = posY;
        dirXNext      = dirX;
        dirYNext      = dirY;
        cntNext       = cnt;
        missRightNext = missRight;

        case (state)
            IDLE: begin
                posXNext = serveX;
                posYNext = serveY;
                if (serve_req) begin
                    stateNext = SERVE;
                    dirXNext  = serve_dir;
                    dirYNext  = 1'b0;
                    cntNext   = serveDelay;
                end
            end
            SERVE: begin
                if (tick) begin
                    cntNext = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        stateNext = PLAY;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    // X axis: both flags at once pins the axis.
                    if (!(coll_x1 && coll_x2)) begin
                        ndx      = coll_x2 ? 1'b1 : (coll_x1 ? 1'b0 : dirX);
                        dirXNext = ndx;
                        if (ndx) begin
                            if (posXE < xLow) begin
                                posXNext      = xMinE[X_W-1:0];
                                missHit       = 1'b1;
                                missRightNext = 1'b0;
                            end else begin
                                posXNext = xDiff[X_W-1:0];
                            end
                        end else begin
                            if (xSum > xMaxE) begin
                                posXNext      = xMaxE[X_W-1:0];
                                missHit       = 1'b1;
                                missRightNext = 1'b1;
                            end else begin
                                posXNext = xSum[X_W-1:0];
                            end
                        end
                    end
                    // Y axis: a nonzero step that reaches a wall lands on it and
                    // bounces, so the ball never sits on the wall heading outward.
                    if (!(coll_y1 && coll_y2)) begin
                        ndy      = coll_y2 ? 1'b1 : (coll_y1 ? 1'b0 : dirY);
                        dirYNext = ndy;
                        if (ndy) begin
                            if (spdY != '0 && posYE <= yLow) begin
                                posYNext = yMinE[Y_W-1:0];
                                dirYNext = 1'b0;
                            end else begin
                                posYNext = yDiff[Y_W-1:0];
                            end
                        end else begin
                            if (spdY != '0 && ySum >= yMaxE) begin
                                posYNext = yMaxE[Y_W-1:0];
                                dirYNext = 1'b1;
                            end else begin
                                posYNext = ySum[Y_W-1:0];
                            end
                        end
                    end
                    if (missHit) begin
                        stateNext = MISS;
                    end
                end
            end
            default: begin
                // MISS: single report cycle, then park at the serve spot.
                stateNext = IDLE;
                posXNext  = serveX;
                posYNext  = serveY;
                dirYNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            posX      <= serveX;
            posY      <= serveY;
            dirX      <= 1'b0;
            dirY      <= 1'b0;
            cnt       <= 8'd0;
            missRight <= 1'b0;
        end else begin
            state     <= stateNext;
            posX      <= posXNext;
            posY      <= posYNext;
            dirX      <= dirXNext;
            dirY      <= dirYNext;
            cnt       <= cntNext;
            missRight <= missRightNext;
        end
    end

    assign ball_x     = posX;
    assign ball_y     = posY;
    assign dir_x      = dirX;
    assign dir_y      = dirY;
    assign in_play    = (state == PLAY);
    assign miss_left  = (state == MISS) && !missRight;
    assign miss_right = (state == MISS) && missRight;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed bench for ball_motion (SERVE_DELAY = 3).
// Drives inputs on the falling edge and samples outputs one half-cycle
// after the rising edge that consumed them.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       coll_x1 = 1'b0, coll_x2 = 1'b0, coll_y1 = 1'b0, coll_y2 = 1'b0;
    logic [2:0] speed_x = 3'd0, speed_y = 3'd0;
    logic       serve_req = 1'b0, serve_dir = 1'b0;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       dir_x, dir_y, in_play, miss_left, miss_right;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ball_motion #(
        .SERVE_DELAY(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .coll_x1   (coll_x1),
        .coll_x2   (coll_x2),
        .coll_y1   (coll_y1),
        .coll_y2   (coll_y2),
        .speed_x   (speed_x),
        .speed_y   (speed_y),
        .serve_req (serve_req),
        .serve_dir (serve_dir),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .in_play   (in_play),
        .miss_left (miss_left),
        .miss_right(miss_right)
    );

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic doTick(input int sx, input int sy, input logic cx1, input logic cx2,
                          input logic cy1, input logic cy2);
        @(negedge clk);
        speed_x = sx[2:0];
        speed_y = sy[2:0];
        coll_x1 = cx1;
        coll_x2 = cx2;
        coll_y1 = cy1;
        coll_y2 = cy2;
        tick    = 1'b1;
        @(negedge clk);
        tick    = 1'b0;
        coll_x1 = 1'b0;
        coll_x2 = 1'b0;
        coll_y1 = 1'b0;
        coll_y2 = 1'b0;
    endtask

    task automatic moveN(input int n, input int sx, input int sy);
        for (int i = 0; i < n; i++) begin
            doTick(sx, sy, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic serve(input logic d);
        @(negedge clk);
        serve_req = 1'b1;
        serve_dir = d;
        @(negedge clk);
        serve_req = 1'b0;
    endtask

    task automatic checkPos(input string tag, input int x, input int y);
        checkVal({tag, ".x"}, int'(ball_x), x);
        checkVal({tag, ".y"}, int'(ball_y), y);
    endtask

    initial begin
        // Reset held for two edges.
        repeat (2) @(negedge clk);
        checkPos("reset", 320, 240);
        checkVal("reset.dir_x", int'(dir_x), 0);
        checkVal("reset.dir_y", int'(dir_y), 0);
        checkVal("reset.in_play", int'(in_play), 0);
        checkVal("reset.miss", int'({miss_left, miss_right}), 0);
        rst = 1'b0;

        // Serve towards -X, three countdown ticks, then first move.
        serve(1'b1);
        checkVal("serve.dir_x", int'(dir_x), 1);
        checkVal("serve.in_play", int'(in_play), 0);
        moveN(2, 3, 0);
        checkVal("serve.t2.in_play", int'(in_play), 0);
        moveN(1, 3, 0);
        checkVal("serve.t3.in_play", int'(in_play), 1);
        checkVal("serve.t3.x", int'(ball_x), 320);
        moveN(1, 3, 0);
        checkPos("serve.t4", 317, 240);

        // Collisions.
        doTick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("cx1.dir_x", int'(dir_x), 0);
        checkVal("cx1.speed0.x", int'(ball_x), 317);
        moveN(11, 7, 0);
        moveN(1, 6, 0);
        checkVal("walk.x", int'(ball_x), 400);
        doTick(3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkVal("cx2.dir_x", int'(dir_x), 1);
        checkVal("cx2.x", int'(ball_x), 397);
        doTick(0, 5, 1'b0, 1'b0, 1'b1, 1'b1);
        checkPos("cyboth", 397, 240);
        checkVal("cyboth.dir_y", int'(dir_y), 0);
        doTick(0, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("cy2.dir_y", int'(dir_y), 1);
        checkVal("cy2.y", int'(ball_y), 236);

        // Bottom wall.
        doTick(0, 7, 1'b1, 1'b0, 1'b1, 1'b0);
        checkVal("cy1.dir_y", int'(dir_y), 0);
        checkVal("cy1.y", int'(ball_y), 243);
        moveN(33, 0, 7);
        moveN(1, 0, 3);
        checkVal("prewall.y", int'(ball_y), 477);
        checkVal("prewall.dir_y", int'(dir_y), 0);
        moveN(1, 3, 2);
        checkPos("wall", 400, 479);
        checkVal("wall.dir_y", int'(dir_y), 1);
        moveN(1, 3, 2);
        checkPos("postwall", 403, 477);

        // Right miss, with a tick ignored during the MISS cycle.
        moveN(33, 7, 0);
        moveN(1, 3, 0);
        checkVal("premiss.x", int'(ball_x), 637);
        moveN(1, 3, 0);
        checkVal("missr.x", int'(ball_x), 639);
        checkVal("missr.pulse", int'({miss_left, miss_right}), 1);
        checkVal("missr.in_play", int'(in_play), 0);
        moveN(1, 3, 3);
        checkVal("missr.after.pulse", int'({miss_left, miss_right}), 0);
        checkPos("missr.idle", 320, 240);
        checkVal("missr.idle.dir_y", int'(dir_y), 0);
        moveN(1, 3, 3);
        checkPos("idle.tick", 320, 240);
        checkVal("idle.in_play", int'(in_play), 0);

        // Left miss.
        serve(1'b1);
        moveN(3, 0, 0);
        moveN(45, 7, 0);
        checkVal("preleft.x", int'(ball_x), 5);
        moveN(1, 7, 0);
        checkVal("missl.x", int'(ball_x), 0);
        checkVal("missl.pulse", int'({miss_left, miss_right}), 2);
        @(negedge clk);
        checkVal("missl.after.pulse", int'({miss_left, miss_right}), 0);
        checkPos("missl.idle", 320, 240);

        // Reset mid-play, coincident with a tick and a collision.
        serve(1'b0);
        moveN(3, 0, 0);
        moveN(1, 2, 0);
        checkVal("rstplay.pre.x", int'(ball_x), 322);
        @(negedge clk);
        rst     = 1'b1;
        tick    = 1'b1;
        coll_x2 = 1'b1;
        speed_x = 3'd3;
        @(negedge clk);
        checkPos("rstplay", 320, 240);
        checkVal("rstplay.dir_x", int'(dir_x), 0);
        checkVal("rstplay.in_play", int'(in_play), 0);
        checkVal("rstplay.miss", int'({miss_left, miss_right}), 0);
        rst     = 1'b0;
        tick    = 1'b0;
        coll_x2 = 1'b0;
        serve(1'b1);
        checkVal("reserve.dir_x", int'(dir_x), 1);
        moveN(3, 0, 0);
        checkVal("reserve.in_play", int'(in_play), 1);
        moveN(1, 1, 0);
        checkVal("reserve.x", int'(ball_x), 319);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
